// File: rtl/boot_switch_if.sv
// Boot-switch signal bundle: CPU fetch/data bus, boot ROM and instruction RAM ports.
// The slave side is the boot switch; the master side is the surrounding system.
interface boot_switch_if #(
  parameter int unsigned IRAM_AW = 15
);
  logic [15:0]        pc;
  logic [15:0]        rom_instruction;
  logic [15:0]        ram_instruction;
  logic [15:0]        instruction;
  logic [15:0]        addressM;
  logic [15:0]        outM;
  logic               writeM;
  logic [IRAM_AW-1:0] iram_addr;
  logic [15:0]        iram_wdata;
  logic               iram_we;
  logic               cpu_reset;
  logic [15:0]        status;

  modport master (
    output pc, rom_instruction, ram_instruction, addressM, outM, writeM,
    input  instruction, iram_addr, iram_wdata, iram_we, cpu_reset, status
  );

  modport slave (
    input  pc, rom_instruction, ram_instruction, addressM, outM, writeM,
    output instruction, iram_addr, iram_wdata, iram_we, cpu_reset, status
  );
endinterface

// File: rtl/boot_switch.sv
// Boot switch: feeds boot-ROM code to the CPU, commits bootloader-written words into
// instruction RAM, then resets the CPU and hands instruction fetch over to RAM for good.
module boot_switch #(
  parameter logic [15:0] BASE         = 16'h6000,
  parameter int unsigned IRAM_AW      = 15,
  parameter int unsigned RESET_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  boot_switch_if.slave bus
);

  typedef enum logic [1:0] {StBoot, StSwitch, StRun} state_e;

  localparam logic [3:0] RstInit = 4'(RESET_CYCLES - 1);

  state_e             state_q;
  logic [IRAM_AW-1:0] load_addr_q;
  logic [IRAM_AW-1:0] wr_addr_q;
  logic [13:0]        word_count_q;
  logic               err_q;
  logic [3:0]         rst_cnt_q;
  logic               iram_we_q;
  logic [15:0]        iram_wdata_q;
  logic               cpu_reset_q;

  logic wr_load_addr;
  logic wr_load_data;
  logic wr_ctrl;
  logic unused_pc;

  assign wr_load_addr = bus.writeM && (bus.addressM == BASE);
  assign wr_load_data = bus.writeM && (bus.addressM == BASE + 16'd1);
  assign wr_ctrl      = bus.writeM && (bus.addressM == BASE + 16'd2);
  assign unused_pc    = ^{bus.pc, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      load_addr_q  <= '0;
      wr_addr_q    <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      rst_cnt_q    <= '0;
      iram_we_q    <= 1'b0;
      iram_wdata_q <= '0;
      cpu_reset_q  <= 1'b0;
    end else begin
      iram_we_q <= 1'b0;
      unique case (state_q)
        StBoot: begin
          // Write address is captured here so a later LOAD_ADDR cannot disturb the commit.
          if (wr_load_data) begin
            iram_we_q    <= 1'b1;
            iram_wdata_q <= bus.outM;
            wr_addr_q    <= load_addr_q;
            load_addr_q  <= load_addr_q + IRAM_AW'(1);
            if (word_count_q != 14'h3FFF) begin
              word_count_q <= word_count_q + 14'd1;
            end
          end
          if (wr_load_addr) begin
            load_addr_q <= bus.outM[IRAM_AW-1:0];
          end
          if (wr_ctrl && bus.outM[0]) begin
            if (word_count_q == '0) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= StSwitch;
              cpu_reset_q <= 1'b1;
              rst_cnt_q   <= RstInit;
            end
          end
        end
        StSwitch: begin
          if (rst_cnt_q == '0) begin
            state_q     <= StRun;
            cpu_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q - 4'd1;
          end
        end
        StRun: begin
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  always_comb begin
    bus.instruction = bus.rom_instruction;
    bus.iram_addr   = iram_we_q ? wr_addr_q : load_addr_q;
    unique case (state_q)
      StBoot:   bus.instruction = bus.rom_instruction;
      StSwitch: bus.instruction = 16'h0000;
      StRun: begin
        bus.instruction = bus.ram_instruction;
        bus.iram_addr   = bus.pc[IRAM_AW-1:0];
      end
      default:  bus.instruction = 16'h0000;
    endcase
  end

  assign bus.iram_we    = iram_we_q;
  assign bus.iram_wdata = iram_wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.status     = {state_q == StRun, err_q, word_count_q};

endmodule

// File: tb/tb_boot_switch.sv
// Directed bench for boot_switch: loads, address wrap, error path, switchover, reset.
module tb_boot_switch;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  boot_switch_if #(.IRAM_AW(15)) bus ();

  boot_switch #(
    .BASE        (16'h6000),
    .IRAM_AW     (15),
    .RESET_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are stable there too.
  task automatic drive(input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.writeM   = w;
    bus.addressM = a;
    bus.outM     = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.writeM   = 1'b0;
    bus.addressM = '0;
    bus.outM     = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks            = 0;
    n_errors            = 0;
    rst_n               = 1'b0;
    bus.pc              = 16'd5;
    bus.rom_instruction = 16'hABCD;
    bus.ram_instruction = 16'h5A5A;
    bus.writeM          = 1'b0;
    bus.addressM        = '0;
    bus.outM            = '0;
    #12;
    check("rst_instr",  bus.instruction, 16'hABCD);
    check("rst_we",     {15'd0, bus.iram_we}, 16'h0000);
    check("rst_status", bus.status, 16'h0000);
    check("rst_cpurst", {15'd0, bus.cpu_reset}, 16'h0000);
    do_reset();

    // CTRL with nothing loaded flags an error and stays in BOOT
    drive(1'b1, 16'h6002, 16'h0001);
    drive(1'b0, 16'h0000, 16'h0000);
    check("err_status", bus.status, 16'h4000);
    check("err_cpurst", {15'd0, bus.cpu_reset}, 16'h0000);
    check("err_instr",  bus.instruction, 16'hABCD);

    do_reset();
    check("rst2_status", bus.status, 16'h0000);

    // Back-to-back loads at 0x10
    drive(1'b1, 16'h6000, 16'h0010);
    drive(1'b1, 16'h6001, 16'h1111);
    drive(1'b1, 16'h6001, 16'h2222);
    check("ld0_we",   {15'd0, bus.iram_we}, 16'h0001);
    check("ld0_addr", {1'b0, bus.iram_addr}, 16'h0010);
    check("ld0_data", bus.iram_wdata, 16'h1111);
    // LOAD_ADDR during the second commit must not disturb it
    drive(1'b1, 16'h6000, 16'h0555);
    check("ld1_we",   {15'd0, bus.iram_we}, 16'h0001);
    check("ld1_addr", {1'b0, bus.iram_addr}, 16'h0011);
    check("ld1_data", bus.iram_wdata, 16'h2222);
    drive(1'b0, 16'h0000, 16'h0000);
    check("ld1_nowe",  {15'd0, bus.iram_we}, 16'h0000);
    check("ld_status", bus.status, 16'h0002);
    check("ld_laddr",  {1'b0, bus.iram_addr}, 16'h0555);

    // Wrap of the load address
    drive(1'b1, 16'h6000, 16'h7FFF);
    drive(1'b1, 16'h6001, 16'hAAAA);
    drive(1'b1, 16'h6001, 16'hBBBB);
    check("wr0_addr", {1'b0, bus.iram_addr}, 16'h7FFF);
    check("wr0_data", bus.iram_wdata, 16'hAAAA);
    drive(1'b0, 16'h0000, 16'h0000);
    check("wr1_we",   {15'd0, bus.iram_we}, 16'h0001);
    check("wr1_addr", {1'b0, bus.iram_addr}, 16'h0000);
    check("wr1_data", bus.iram_wdata, 16'hBBBB);
    drive(1'b0, 16'h0000, 16'h0000);
    check("wr_status", bus.status, 16'h0004);
    check("wr_laddr",  {1'b0, bus.iram_addr}, 16'h0001);

    // CTRL with bit0 clear is a no-op
    drive(1'b1, 16'h6002, 16'h0000);
    drive(1'b0, 16'h0000, 16'h0000);
    check("ctl0_cpurst", {15'd0, bus.cpu_reset}, 16'h0000);
    check("ctl0_instr",  bus.instruction, 16'hABCD);

    // Switchover: cpu_reset for four cycles, writes ignored meanwhile
    drive(1'b1, 16'h6002, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h6001, 16'hDEAD);
      check($sformatf("sw%0d_cpurst", i), {15'd0, bus.cpu_reset}, 16'h0001);
      check($sformatf("sw%0d_instr", i), bus.instruction, 16'h0000);
      check($sformatf("sw%0d_we", i), {15'd0, bus.iram_we}, 16'h0000);
    end
    drive(1'b0, 16'h0000, 16'h0000);
    check("run_cpurst", {15'd0, bus.cpu_reset}, 16'h0000);
    check("run_status", bus.status, 16'h8004);

    bus.pc              = 16'h1234;
    bus.ram_instruction = 16'hBEEF;
    #1;
    check("run_instr", bus.instruction, 16'hBEEF);
    check("run_addr0", {1'b0, bus.iram_addr}, 16'h1234);
    bus.pc = 16'h8003;
    #1;
    check("run_addr1", {1'b0, bus.iram_addr}, 16'h0003);

    drive(1'b1, 16'h6001, 16'hCAFE);
    drive(1'b1, 16'h6002, 16'h0001);
    check("run_nowe", {15'd0, bus.iram_we}, 16'h0000);
    drive(1'b0, 16'h0000, 16'h0000);
    check("run_lock_status", bus.status, 16'h8004);
    check("run_lock_cpurst", {15'd0, bus.cpu_reset}, 16'h0000);

    // Reset during the second SWITCH cycle
    do_reset();
    bus.pc = 16'd5;
    drive(1'b1, 16'h6001, 16'h3333);
    drive(1'b1, 16'h6002, 16'h0001);
    drive(1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 16'h0000, 16'h0000);
    check("mid_cpurst_pre", {15'd0, bus.cpu_reset}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_cpurst", {15'd0, bus.cpu_reset}, 16'h0000);
    check("mid_instr",  bus.instruction, 16'hABCD);
    check("mid_status", bus.status, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_switch.md
Name: boot_switch

Overview:
- Sits between the 256-word boot ROM, the instruction RAM and the Hack CPU.
- While booting, it forwards boot-ROM instructions to the CPU.
- It accepts program words that the bootloader writes through memory-mapped load registers and commits them into instruction RAM.
- On command, it pulses the CPU reset and permanently switches the instruction source to instruction RAM.

Parameters:
- BASE, 16'h6000: memory-mapped base address of the load registers.
- IRAM_AW, 15: instruction RAM address width.
- RESET_CYCLES, 4: cycles for which cpu_reset is held during switchover (1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  16  CPU program counter.
- rom_instruction  input  16  boot ROM output (combinational, addressed by pc).
- ram_instruction  input  16  instruction RAM read data (combinational, addressed by iram_addr).
- instruction  output  16  instruction delivered to the CPU.
- addressM  input  16  CPU data address.
- outM  input  16  CPU write data.
- writeM  input  1  CPU write strobe.
- iram_addr  output  IRAM_AW  instruction RAM address.
- iram_wdata  output  16  instruction RAM write data.
- iram_we  output  1  instruction RAM write enable.
- cpu_reset  output  1  active-high CPU reset request.
- status  output  16  read-back word: {run, err, word_count[13:0]}.

Behaviour:
- Interface (already decided): one clock clk; reset rst_n is asynchronous, active-low.
- Register map, decoded on addressM while writeM=1:
  - BASE+0 LOAD_ADDR: load_addr <= outM[IRAM_AW-1:0].
  - BASE+1 LOAD_DATA: write the word into instruction RAM.
  - BASE+2 CTRL: outM[0]=1 requests the run switchover.
  - Other addresses are ignored.
- States: BOOT, SWITCH, RUN.
- Reset values: state=BOOT, load_addr=0, word_count=0, err=0, rst_cnt=0, iram_we=0, iram_wdata=0, cpu_reset=0.
- BOOT, instruction source:
  - instruction = rom_instruction, combinational, zero latency.
  - iram_addr = load_addr.
- BOOT, LOAD_DATA write (cycle N):
  - Registered outputs at edge N+1: iram_we=1 for exactly one cycle, iram_wdata=outM, iram_addr = load_addr as it was at cycle N.
  - At edge N+1, load_addr increments. It wraps from 2^IRAM_AW-1 to 0.
  - word_count increments and saturates at 14'h3FFF.
- Back-to-back LOAD_DATA writes on consecutive cycles each produce one write pulse, at consecutive addresses.
- A LOAD_ADDR write in the same cycle that a write is being committed does not corrupt it; the committed address is the one latched at the request.
- BOOT, CTRL write with bit0=1:
  - If word_count=0: set err=1 and stay in BOOT.
  - Otherwise: go to SWITCH, set cpu_reset=1, rst_cnt=RESET_CYCLES-1.
  - CTRL with bit0=0 has no effect.
- SWITCH:
  - instruction = 16'h0000 (harmless @0).
  - rst_cnt decrements each cycle.
  - When rst_cnt=0: go to RUN and clear cpu_reset in the same edge.
  - Total cpu_reset high time = RESET_CYCLES cycles.
  - All register writes are ignored.
- RUN:
  - instruction = ram_instruction.
  - iram_addr = pc[IRAM_AW-1:0].
  - iram_we=0 forever.
  - All register writes are ignored (locked until rst_n).
- Status: status[15]=1 in RUN, status[14]=err, status[13:0]=word_count.
- A pending iram_we pulse issued just before the CTRL write completes normally.
- Reset mid-SWITCH or in RUN returns asynchronously to BOOT:
  - cpu_reset drops to 0 immediately.
  - word_count=0 and err=0.
  - Instruction RAM contents are untouched.

Test Plan:
- Reset then BOOT, pc=5, rom_instruction=16'hABCD -> instruction=16'hABCD, iram_we=0, status=16'h0000.
- Write LOAD_ADDR=16'h0010, then LOAD_DATA 16'h1111 and 16'h2222 on consecutive cycles -> two single-cycle iram_we pulses at addresses 0x10 and 0x11 with those data; status=16'h0002.
- LOAD_ADDR=16'h7FFF, two LOAD_DATA writes -> write addresses 0x7FFF then 0x0000 (wrap).
- CTRL=1 with word_count=0 -> err=1, status=16'h4000, state stays BOOT, cpu_reset=0.
- After 3 loads, CTRL=1 -> cpu_reset high for exactly 4 cycles with instruction=0.
  - Then RUN: status[15]=1, instruction=ram_instruction, iram_addr tracks pc.
  - A later LOAD_DATA write produces no iram_we.
- Assert rst_n low during SWITCH cycle 2 -> cpu_reset=0 immediately, instruction=rom_instruction, status=0.
